// File: rtl/uart_tx8_pkg.sv
// Shared UART definitions: data width, FSM encodings, bit-period rounding.
package uart_tx8_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } txState_t;

  // Clocks per bit, rounded to nearest.
  function automatic int clksPerBit(input int clockRate, input int baudRate);
    return (clockRate + baudRate / 2) / baudRate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Divide-by-N bit timer with synchronous restart; bitTick marks the last clock of each bit.
module uart_baud_tick #(
  parameter int N = 1250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bitTick
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt;

  // Count 0..N-1 and wrap; restart realigns the count to a new frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (restart || cnt == LAST) cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

  assign bitTick = (cnt == LAST);

endmodule

// File: rtl/uart_tx8.sv
// 8N1 UART transmitter with a one-byte holding register for gapless back-to-back frames.
module uart_tx8
  import uart_tx8_pkg::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              txEn,
  input  logic              txStart,
  input  logic [DATA_W-1:0] txIn,
  output logic              txReady,
  output logic              txBusy,
  output logic              txDone,
  output logic              txOut
);

  localparam int CPB = clksPerBit(CLOCK_RATE, BAUD_RATE);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  txState_t          state, stateNext;
  logic [2:0]        bitIdx, bitIdxNext;
  logic [DATA_W-1:0] shiftReg, shiftNext;
  logic [DATA_W-1:0] holdReg, holdNext;
  logic              holdFull, holdFullNext;
  logic [DATA_W-1:0] loadByte;
  logic              accept, load, frameEnd, bitTick, txOutNext;

  assign accept = txStart & txEn & txReady;

  uart_baud_tick #(.N(CPB)) uBaud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (load),
    .bitTick (bitTick)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bitIdx   <= '0;
      shiftReg <= '0;
      holdReg  <= '0;
      holdFull <= 1'b0;
      txOut    <= 1'b1;
      txBusy   <= 1'b0;
      txDone   <= 1'b0;
      txReady  <= 1'b1;
    end else begin
      state    <= stateNext;
      bitIdx   <= bitIdxNext;
      shiftReg <= shiftNext;
      holdReg  <= holdNext;
      holdFull <= holdFullNext;
      txOut    <= txOutNext;
      txBusy   <= (stateNext != ST_IDLE);
      txDone   <= frameEnd;
      txReady  <= ~holdFullNext;
    end
  end

  // Next-state: bit sequencing, frame (re)load from input or hold, hold capture.
  always_comb begin
    stateNext    = state;
    bitIdxNext   = bitIdx;
    shiftNext    = shiftReg;
    holdNext     = holdReg;
    holdFullNext = holdFull;
    loadByte     = txIn;
    load         = 1'b0;
    frameEnd     = 1'b0;
    case (state)
      ST_IDLE:  if (accept) load = 1'b1;
      ST_START: if (bitTick) begin
        stateNext  = ST_DATA;
        bitIdxNext = '0;
      end
      ST_DATA:  if (bitTick) begin
        shiftNext = shiftReg >> 1;
        if (bitIdx == 3'd7) begin
          stateNext  = ST_STOP;
          bitIdxNext = '0;
        end else begin
          bitIdxNext = bitIdx + 3'd1;
        end
      end
      ST_STOP:  if (bitTick) begin
        if (bitIdx == STOP_LAST) begin
          frameEnd = 1'b1;
          if (holdFull) begin
            load         = 1'b1;
            loadByte     = holdReg;
            holdFullNext = 1'b0;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            stateNext = ST_IDLE;
          end
        end else begin
          bitIdxNext = bitIdx + 3'd1;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
    // Bytes not going straight to the line are parked in hold.
    if (accept && !load) begin
      holdNext     = txIn;
      holdFullNext = 1'b1;
    end
    if (load) begin
      stateNext  = ST_START;
      shiftNext  = loadByte;
      bitIdxNext = '0;
    end
    txOutNext = (stateNext == ST_DATA) ? shiftNext[0] : (stateNext != ST_START);
  end

endmodule

// File: tb/tb_uart_tx8.sv
// Scoreboard bench for uart_tx8: stimulus pushes expected bytes, a line monitor decodes frames.
module tb_uart_tx8;

  localparam int CPB    = 16;            // (160+5)/10 and (155+5)/10
  localparam int FRAME1 = 10 * CPB;      // 160
  localparam int FRAME2 = 11 * CPB;      // 176

  logic clk = 1'b0;
  logic rst_n;
  logic txEn, txStart;
  logic [7:0] txIn;
  logic txReady, txBusy, txDone, txOut;
  logic txStart2;
  logic [7:0] txIn2;
  logic txReady2, txBusy2, txDone2, txOut2;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [7:0] data; bit gapless; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  uart_tx8 #(.CLOCK_RATE(160), .BAUD_RATE(10), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .txEn(txEn), .txStart(txStart), .txIn(txIn),
    .txReady(txReady), .txBusy(txBusy), .txDone(txDone), .txOut(txOut)
  );

  uart_tx8 #(.CLOCK_RATE(155), .BAUD_RATE(10), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .txEn(1'b1), .txStart(txStart2), .txIn(txIn2),
    .txReady(txReady2), .txBusy(txBusy2), .txDone(txDone2), .txOut(txOut2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    txIn = b; txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0; txIn = ~b;
  endtask

  task automatic expectByte(input logic [7:0] b, input bit gapless);
    exp_t e;
    e.data = b; e.gapless = gapless;
    sb.push_back(e);
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 4 * FRAME1 && sb.size() != 0; i++) @(negedge clk);
    check({name, "_drain_left"}, sb.size(), 0);
    sb.delete();
  endtask

  // Line monitor: decode frames mid-bit, pop and compare on each completed frame.
  initial begin : monitor
    bit carry, gap, aborted, startOk, stopOk;
    int doneAt;
    logic [7:0] got;
    exp_t e;
    carry = 1'b0;
    forever begin
      if (!carry) begin
        gap = 1'b0;
        do @(negedge clk); while (!(rst_n === 1'b1 && txOut === 1'b0));
      end else begin
        gap = 1'b1;
      end
      carry = 1'b0; aborted = 1'b0; doneAt = -1;
      startOk = 1'b0; stopOk = 1'b0; got = '0;
      for (int k = 1; k <= FRAME1; k++) begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin aborted = 1'b1; break; end
        if (txDone === 1'b1 && doneAt < 0) doneAt = k;
        if (k == CPB / 2) startOk = (txOut === 1'b0);
        if (k % CPB == CPB / 2 && k / CPB >= 1 && k / CPB <= 8) got[k / CPB - 1] = txOut;
        if (k == 9 * CPB + CPB / 2) stopOk = (txOut === 1'b1);
      end
      if (!aborted) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL mon_unexpected: frame %0h with empty scoreboard", got);
        end else begin
          e = sb.pop_front();
          check("mon_data", got, e.data);
          check("mon_done_at", doneAt, FRAME1);
          check("mon_gapless", gap, e.gapless);
          check("mon_framing", {startOk, stopOk}, 2'b11);
        end
        carry = (txOut === 1'b0);
      end
    end
  end

  initial begin : stim
    logic [10:0] exp2;
    bit stayedHigh;
    rst_n = 1'b0; txEn = 1'b1; txStart = 1'b0; txIn = '0;
    txStart2 = 1'b0; txIn2 = '0;
    repeat (5) @(negedge clk);
    check("rst_txOut", txOut, 1);
    check("rst_txBusy", txBusy, 0);
    check("rst_txReady", txReady, 1);
    check("rst_txDone", txDone, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte from idle, first-edge latency.
    expectByte(8'h55, 1'b0);
    sendByte(8'h55);
    check("lat_txOut", txOut, 0);
    check("lat_txBusy", txBusy, 1);
    waitDrain("t2");
    repeat (20) @(negedge clk);
    check("t2_idle_busy", txBusy, 0);

    // Held byte follows with no gap; extra request while hold full is dropped.
    expectByte(8'hA5, 1'b0);
    sendByte(8'hA5);
    repeat (40) @(negedge clk);
    check("t3_ready_before", txReady, 1);
    expectByte(8'h3C, 1'b1);
    sendByte(8'h3C);
    check("t3_ready_held", txReady, 0);
    sendByte(8'hFF);
    check("t4_ready_still", txReady, 0);
    waitDrain("t3");
    repeat (20) @(negedge clk);
    check("t3_ready_after", txReady, 1);
    check("t3_busy_after", txBusy, 0);

    // Disabled requests are ignored; disabling mid-frame does not cut the frame.
    txEn = 1'b0;
    sendByte(8'h77);
    stayedHigh = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (txOut !== 1'b1 || txBusy !== 1'b0) stayedHigh = 1'b0;
    end
    check("t5_en_off_idle", stayedHigh, 1);
    txEn = 1'b1;
    expectByte(8'hC3, 1'b0);
    sendByte(8'hC3);
    repeat (30) @(negedge clk);
    txEn = 1'b0;
    waitDrain("t5");
    txEn = 1'b1;
    repeat (10) @(negedge clk);

    // Async reset during data bit 3 with a byte held.
    sendByte(8'h11);
    repeat (5) @(negedge clk);
    sendByte(8'h22);
    repeat (65) @(negedge clk);
    check("t6_pre_busy", txBusy, 1);
    #1 rst_n = 1'b0;
    #1 check("t6_async_txOut", txOut, 1);
    check("t6_async_busy", txBusy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_hold_cleared", txReady, 1);
    check("t6_line_idle", txOut, 1);
    repeat (5) @(negedge clk);
    expectByte(8'h81, 1'b0);
    sendByte(8'h81);
    waitDrain("t6");
    repeat (200) @(negedge clk);
    check("t6_no_extra_busy", txBusy, 0);

    // Two stop bits: 11-bit frame, txDone only after the second stop bit.
    exp2 = {1'b1, 1'b1, 8'h96, 1'b0};
    @(negedge clk);
    txIn2 = 8'h96; txStart2 = 1'b1;
    @(negedge clk);
    txStart2 = 1'b0; txIn2 = 8'h00;
    check("sb2_latency", txOut2, 0);
    for (int k = 1; k <= FRAME2; k++) begin
      @(negedge clk);
      if (k % CPB == CPB / 2) check($sformatf("sb2_bit%0d", k / CPB), txOut2, exp2[k / CPB]);
      if (k == FRAME1) check("sb2_done_early", txDone2, 0);
      if (k == FRAME1 + CPB / 2) check("sb2_busy_stop2", txBusy2, 1);
    end
    check("sb2_done", txDone2, 1);
    @(negedge clk);
    check("sb2_done_pulse", txDone2, 0);
    check("sb2_idle", txBusy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
